reg_bus_arbiter: RTL

//  Shares the single peripheral register-file port (GPIO/timer regs, addr[5:2], wben, r_wn) between two

---
 rtl/reg_bus_arbiter_pkg.sv | 13 +
 rtl/reg_bus_arbiter_if.sv | 26 ++
 rtl/reg_bus_arbiter_rr_pick2.sv | 27 ++
 rtl/reg_bus_arbiter.sv | 129 ++++++++++++
 4 files changed

// File: rtl/reg_bus_arbiter_pkg.sv
// Shared types for the register-bus arbiter: FSM state encoding and master indices.
package reg_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_RESP  = 2'd2
  } arb_state_e;

  localparam logic M0 = 1'b0;
  localparam logic M1 = 1'b1;

endpackage

// File: rtl/reg_bus_arbiter_if.sv
// Requester channel of the register-bus arbiter (one instance per master).
interface reg_bus_arbiter_if #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 32,
  parameter int WBEN_W = 4
);
  logic              req;
  logic [ADDR_W-1:0] addr;
  logic              r_wn;
  logic [WBEN_W-1:0] wben;
  logic [DATA_W-1:0] wdata;
  logic              lock;
  logic              gnt;
  logic              rvalid;
  logic [DATA_W-1:0] rdata;

  modport master (
    output req, addr, r_wn, wben, wdata, lock,
    input  gnt, rvalid, rdata
  );

  modport slave (
    input  req, addr, r_wn, wben, wdata, lock,
    output gnt, rvalid, rdata
  );
endinterface

// File: rtl/reg_bus_arbiter_rr_pick2.sv
// Combinational 2-way round-robin picker; a lock owner with an active request always wins.
module rr_pick2
  import reg_arb_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last,
  input  logic [1:0] lock_own,
  output logic       sel,
  output logic       any
);

  // Lock owner first, then single requester, then alternate on a tie.
  always_comb begin
    any = |req;
    sel = M0;
    if (|(lock_own & req)) begin
      sel = lock_own[1];
    end else if (req == 2'b11) begin
      sel = ~last;
    end else if (req[1]) begin
      sel = M1;
    end else begin
      sel = M0;
    end
  end

endmodule

// File: rtl/reg_bus_arbiter.sv
// Two-master round-robin arbiter for the peripheral register port, registered drive and read return.
// Optional grant locking is built when REG_ARB_LOCK_EN is defined.
module reg_bus_arbiter
  import reg_arb_pkg::*;
#(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 32,
  parameter int WBEN_W = 4
) (
  input  logic              clk,
  input  logic              reset,
  reg_bus_arbiter_if.slave  m0,
  reg_bus_arbiter_if.slave  m1,
  output logic [ADDR_W-1:0] reg_addr,
  output logic [WBEN_W-1:0] reg_wben,
  output logic              reg_r_wn,
  output logic [DATA_W-1:0] reg_wdata,
  input  logic [DATA_W-1:0] reg_rdata
);

  arb_state_e        state_r;
  logic              last_r;
  logic              win_r;
  logic              lock_r;
  logic              lock_idx_r;
  logic [1:0]        gnt_r;
  logic [1:0]        rvalid_r;
  logic [DATA_W-1:0] rdata_r;

  logic [1:0]        req_s;
  logic [1:0]        lock_own_s;
  logic              sel_s;
  logic              any_s;
  logic              cap_lock_s;
  logic [ADDR_W-1:0] cap_addr_s;
  logic              cap_r_wn_s;
  logic [WBEN_W-1:0] cap_wben_s;
  logic [DATA_W-1:0] cap_wdata_s;

  assign req_s      = {m1.req, m0.req};
  assign lock_own_s = lock_r ? (lock_idx_r ? 2'b10 : 2'b01) : 2'b00;

  rr_pick2 u_pick (
    .req      (req_s),
    .last     (last_r),
    .lock_own (lock_own_s),
    .sel      (sel_s),
    .any      (any_s)
  );

  assign cap_addr_s  = sel_s ? m1.addr  : m0.addr;
  assign cap_r_wn_s  = sel_s ? m1.r_wn  : m0.r_wn;
  assign cap_wben_s  = sel_s ? m1.wben  : m0.wben;
  assign cap_wdata_s = sel_s ? m1.wdata : m0.wdata;

`ifdef REG_ARB_LOCK_EN
  assign cap_lock_s = sel_s ? m1.lock : m0.lock;
`else
  logic unused_lock_s;
  assign unused_lock_s = m0.lock ^ m1.lock;
  assign cap_lock_s    = 1'b0;
`endif

  assign m0.gnt    = gnt_r[0];
  assign m1.gnt    = gnt_r[1];
  assign m0.rvalid = rvalid_r[0];
  assign m1.rvalid = rvalid_r[1];
  assign m0.rdata  = rdata_r;
  assign m1.rdata  = rdata_r;

  // Transaction FSM: capture winner, drive the register port for one cycle, return response.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r    <= ST_IDLE;
      last_r     <= M1;
      win_r      <= M0;
      lock_r     <= 1'b0;
      lock_idx_r <= M0;
      gnt_r      <= 2'b00;
      rvalid_r   <= 2'b00;
      rdata_r    <= {DATA_W{1'b0}};
      reg_addr   <= {ADDR_W{1'b0}};
      reg_wben   <= {WBEN_W{1'b0}};
      reg_r_wn   <= 1'b1;
      reg_wdata  <= {DATA_W{1'b0}};
    end else begin
      case (state_r)
        ST_IDLE, ST_RESP: begin
          rvalid_r <= 2'b00;
          if (any_s) begin
            state_r    <= ST_ISSUE;
            gnt_r      <= sel_s ? 2'b10 : 2'b01;
            last_r     <= sel_s;
            win_r      <= sel_s;
            lock_r     <= cap_lock_s;
            lock_idx_r <= sel_s;
            reg_addr   <= cap_addr_s;
            reg_r_wn   <= cap_r_wn_s;
            reg_wben   <= cap_r_wn_s ? {WBEN_W{1'b0}} : cap_wben_s;
            reg_wdata  <= cap_wdata_s;
          end else begin
            // No requester at an arbitration point also drops any held lock.
            state_r  <= ST_IDLE;
            gnt_r    <= 2'b00;
            lock_r   <= 1'b0;
            reg_wben <= {WBEN_W{1'b0}};
            reg_r_wn <= 1'b1;
          end
        end
        ST_ISSUE: begin
          state_r  <= ST_RESP;
          gnt_r    <= 2'b00;
          rvalid_r <= win_r ? 2'b10 : 2'b01;
          rdata_r  <= reg_rdata;
          reg_wben <= {WBEN_W{1'b0}};
          reg_r_wn <= 1'b1;
        end
        default: begin
          state_r  <= ST_IDLE;
          gnt_r    <= 2'b00;
          rvalid_r <= 2'b00;
          reg_wben <= {WBEN_W{1'b0}};
          reg_r_wn <= 1'b1;
        end
      endcase
    end
  end

endmodule
